// File: rtl/dct_pkg.sv
// Shared definitions for the row DCT, column DCT and the transpose buffer between them.
package dct_pkg;
    localparam int DCT_N  = 8;
    localparam int COEF_W = 12;
    localparam int IDX_W  = 3;

    typedef logic signed [COEF_W-1:0] coef_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_t;
endpackage

// File: rtl/dct_tbuf_bank.sv
// One 8x8 coefficient bank: whole rows are written, whole columns are read combinationally.
module dct_tbuf_bank
    import dct_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [IDX_W-1:0]          i_wr_row,
    input  logic [DCT_N*COEF_W-1:0]   i_wr_data,
    input  logic [IDX_W-1:0]          i_rd_col,
    output logic [DCT_N*COEF_W-1:0]   o_rd_data
);
    // Indexed [row][col]; contents survive reset since a stale block is never read out.
    coef_t mem [DCT_N][DCT_N];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int k = 0; k < DCT_N; k++) begin
                mem[i_wr_row][k] <= i_wr_data[k*COEF_W +: COEF_W];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DCT_N; gi++) begin : g_rd
            assign o_rd_data[gi*COEF_W +: COEF_W] = mem[gi][i_rd_col];
        end
    endgenerate
endmodule

// File: rtl/dct_transpose_buf.sv
// Row-in / column-out transpose buffer between the 1-D DCT passes.
// Define TRANSPOSE_PINGPONG_EN for two banks (1 block / 8 cycles); otherwise one bank.
module dct_transpose_buf
    import dct_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic signed [COEF_W-1:0] i_data0,
    input  logic signed [COEF_W-1:0] i_data1,
    input  logic signed [COEF_W-1:0] i_data2,
    input  logic signed [COEF_W-1:0] i_data3,
    input  logic signed [COEF_W-1:0] i_data4,
    input  logic signed [COEF_W-1:0] i_data5,
    input  logic signed [COEF_W-1:0] i_data6,
    input  logic signed [COEF_W-1:0] i_data7,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic signed [COEF_W-1:0] o_data0,
    output logic signed [COEF_W-1:0] o_data1,
    output logic signed [COEF_W-1:0] o_data2,
    output logic signed [COEF_W-1:0] o_data3,
    output logic signed [COEF_W-1:0] o_data4,
    output logic signed [COEF_W-1:0] o_data5,
    output logic signed [COEF_W-1:0] o_data6,
    output logic signed [COEF_W-1:0] o_data7,
    output logic [IDX_W-1:0]         o_col,
    output logic                     o_sob,
    output logic                     o_drop
);
    localparam int ROW_W = DCT_N * COEF_W;

    logic [ROW_W-1:0] wr_data, rd_data, o_data_q, o_data_d;
    logic [IDX_W-1:0] wr_row_q, wr_row_d, col_q, col_d, o_col_q, o_col_d;
    logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;
    rd_state_t        state_q, state_d;
    logic             o_valid_q, o_valid_d, o_sob_q, o_sob_d, drop_q, drop_d;
    logic             accept;

    assign wr_data = {i_data7, i_data6, i_data5, i_data4, i_data3, i_data2, i_data1, i_data0};
    assign o_ready = !full_q[wr_bank_q];
    assign accept  = i_valid && o_ready;

`ifdef TRANSPOSE_PINGPONG_EN
    logic [ROW_W-1:0] bank_rd [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            dct_tbuf_bank u_bank (
                .i_clk     (i_clk),
                .i_we      (accept && (wr_bank_q == 1'(gi))),
                .i_wr_row  (wr_row_q),
                .i_wr_data (wr_data),
                .i_rd_col  (col_q),
                .o_rd_data (bank_rd[gi])
            );
        end
    endgenerate

    assign rd_data = bank_rd[rd_bank_q];
`else
    dct_tbuf_bank u_bank (
        .i_clk     (i_clk),
        .i_we      (accept),
        .i_wr_row  (wr_row_q),
        .i_wr_data (wr_data),
        .i_rd_col  (col_q),
        .o_rd_data (rd_data)
    );
`endif

    always_comb begin
        wr_row_d  = wr_row_q;
        wr_bank_d = wr_bank_q;
        full_d    = full_q;
        drop_d    = drop_q | (i_valid & ~o_ready);
        state_d   = state_q;
        col_d     = col_q;
        rd_bank_d = rd_bank_q;
        o_valid_d = 1'b0;
        o_sob_d   = 1'b0;
        o_col_d   = o_col_q;
        o_data_d  = o_data_q;

        if (accept) begin
            wr_row_d = wr_row_q + IDX_W'(1);
            if (wr_row_q == IDX_W'(DCT_N - 1)) begin
                full_d[wr_bank_q] = 1'b1;
`ifdef TRANSPOSE_PINGPONG_EN
                wr_bank_d = ~wr_bank_q;
`endif
            end
        end

        // The read side looks at full_d so col 0 is registered one edge after row 7 lands.
        case (state_q)
            ST_IDLE: begin
                if (full_d != 2'b00) begin
                    state_d   = ST_READ;
                    col_d     = '0;
                    rd_bank_d = !full_d[0];
                end
            end
            ST_READ: begin
                o_valid_d = 1'b1;
                o_sob_d   = (col_q == '0);
                o_col_d   = col_q;
                o_data_d  = rd_data;
                col_d     = col_q + IDX_W'(1);
                if (col_q == IDX_W'(DCT_N - 1)) begin
                    full_d[rd_bank_q] = 1'b0;
                    if (full_d[~rd_bank_q]) begin
                        col_d     = '0;
                        rd_bank_d = ~rd_bank_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_row_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= 2'b00;
            drop_q    <= 1'b0;
            state_q   <= ST_IDLE;
            col_q     <= '0;
            rd_bank_q <= 1'b0;
            o_valid_q <= 1'b0;
            o_sob_q   <= 1'b0;
            o_col_q   <= '0;
            o_data_q  <= '0;
        end else begin
            wr_row_q  <= wr_row_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            drop_q    <= drop_d;
            state_q   <= state_d;
            col_q     <= col_d;
            rd_bank_q <= rd_bank_d;
            o_valid_q <= o_valid_d;
            o_sob_q   <= o_sob_d;
            o_col_q   <= o_col_d;
            o_data_q  <= o_data_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_sob   = o_sob_q;
    assign o_col   = o_col_q;
    assign o_drop  = drop_q;
    assign o_data0 = o_data_q[0*COEF_W +: COEF_W];
    assign o_data1 = o_data_q[1*COEF_W +: COEF_W];
    assign o_data2 = o_data_q[2*COEF_W +: COEF_W];
    assign o_data3 = o_data_q[3*COEF_W +: COEF_W];
    assign o_data4 = o_data_q[4*COEF_W +: COEF_W];
    assign o_data5 = o_data_q[5*COEF_W +: COEF_W];
    assign o_data6 = o_data_q[6*COEF_W +: COEF_W];
    assign o_data7 = o_data_q[7*COEF_W +: COEF_W];
endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed bench for dct_transpose_buf; the last scenario depends on TRANSPOSE_PINGPONG_EN.
module tb_dct_transpose_buf;
    logic              clk = 1'b0;
    logic              i_rst, i_valid;
    logic signed [11:0] d_in [8];
    logic signed [11:0] o_d  [8];
    logic              o_ready, o_valid, o_sob, o_drop;
    logic [2:0]        o_col;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdy_low, drop_cnt;
    int pat [24][8];
    int acc_edge [$];
    int cap_cyc [$];
    int cap_col [$];
    int cap_sob [$];
    int cap_d   [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dct_transpose_buf dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid),
        .i_data0(d_in[0]), .i_data1(d_in[1]), .i_data2(d_in[2]), .i_data3(d_in[3]),
        .i_data4(d_in[4]), .i_data5(d_in[5]), .i_data6(d_in[6]), .i_data7(d_in[7]),
        .o_ready(o_ready), .o_valid(o_valid),
        .o_data0(o_d[0]), .o_data1(o_d[1]), .o_data2(o_d[2]), .o_data3(o_d[3]),
        .o_data4(o_d[4]), .o_data5(o_d[5]), .o_data6(o_d[6]), .o_data7(o_d[7]),
        .o_col(o_col), .o_sob(o_sob), .o_drop(o_drop)
    );

    // Inputs settle 1 time unit after each rising edge, so mid-cycle values describe the next edge.
    always @(negedge clk) begin
        if (i_valid && o_ready) acc_edge.push_back(cyc + 1);
        if (i_valid && !o_ready) drop_cnt++;
        if (!o_ready) rdy_low++;
        if (o_valid) begin
            cap_cyc.push_back(cyc);
            cap_col.push_back(int'(o_col));
            cap_sob.push_back(int'(o_sob));
            for (int k = 0; k < 8; k++) cap_d.push_back(int'(o_d[k]));
            $display("edge %0d: col=%0d sob=%0d d0=%0d d7=%0d", cyc, o_col, o_sob, o_d[0], o_d[7]);
        end
    end

    task automatic check_val(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input bit v);
        i_valid = v;
        for (int k = 0; k < 8; k++) d_in[k] = 12'(pat[r][k]);
        step();
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic clear_cap();
        acc_edge.delete(); cap_cyc.delete(); cap_col.delete(); cap_sob.delete(); cap_d.delete();
        rdy_low  = 0;
        drop_cnt = 0;
    endtask

    task automatic fill_lin(input int n, input int base);
        for (int r = 0; r < n; r++)
            for (int k = 0; k < 8; k++) pat[r][k] = base + 16 * r + k;
    endtask

    // Column j of block b must hold element (j%8) of rows 8b..8b+7, with no gaps between columns.
    task automatic check_blocks(input string tag, input int nblk);
        int lat;
        check_val({tag, "_ncol"}, cap_col.size(), nblk * 8);
        lat = (acc_edge.size() >= 8 && cap_cyc.size() > 0) ? cap_cyc[0] - acc_edge[7] : -1;
        check_val({tag, "_latency"}, lat, 1);
        for (int j = 0; j < cap_col.size() && j < nblk * 8; j++) begin
            check_val($sformatf("%s_col[%0d]", tag, j), cap_col[j], j % 8);
            check_val($sformatf("%s_sob[%0d]", tag, j), cap_sob[j], (j % 8 == 0) ? 1 : 0);
            if (j > 0) check_val($sformatf("%s_gap[%0d]", tag, j), cap_cyc[j] - cap_cyc[j-1], 1);
            for (int k = 0; k < 8; k++)
                check_val($sformatf("%s_d[%0d][%0d]", tag, j, k), cap_d[j*8+k], pat[(j/8)*8 + k][j%8]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b0;
        i_valid = 1'b0;
        for (int k = 0; k < 8; k++) d_in[k] = '0;
        clear_cap();
        repeat (3) step();
        check_val("rst_valid", int'(o_valid), 0);
        check_val("rst_sob",   int'(o_sob),   0);
        check_val("rst_col",   int'(o_col),   0);
        check_val("rst_drop",  int'(o_drop),  0);
        check_val("rst_d0",    int'(o_d[0]),  0);
        check_val("rst_d7",    int'(o_d[7]),  0);
        check_val("rst_ready", int'(o_ready), 1);
        i_rst = 1'b1;
        step();

        // Linear ramp: col c carries {c, 16+c, ..., 112+c}.
        clear_cap();
        fill_lin(8, 0);
        for (int r = 0; r < 8; r++) drive(r, 1'b1);
        idle(12);
        check_blocks("lin", 1);
        check_val("hold_col",   int'(o_col),  7);
        check_val("hold_d0",    int'(o_d[0]), 7);
        check_val("hold_d7",    int'(o_d[7]), 119);
        check_val("hold_valid", int'(o_valid), 0);

        // Signed extremes: row 3 at -2048, all others at 2047.
        clear_cap();
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) pat[r][k] = (r == 3) ? -2048 : 2047;
        for (int r = 0; r < 8; r++) drive(r, 1'b1);
        idle(12);
        check_blocks("sgn", 1);

        // i_valid toggling 1/0 over 16 cycles.
        clear_cap();
        fill_lin(8, 1000);
        for (int c = 0; c < 16; c++) drive(c / 2, (c % 2) == 0);
        idle(12);
        check_val("tog_accepted", acc_edge.size(), 8);
        check_blocks("tog", 1);

        // Reset after 5 rows discards the partial block.
        clear_cap();
        fill_lin(8, 500);
        for (int r = 0; r < 5; r++) drive(r, 1'b1);
        i_valid = 1'b0;
        i_rst = 1'b0;
        step();
        i_rst = 1'b1;
        idle(12);
        check_val("rst_mid_no_valid", cap_col.size(), 0);
        clear_cap();
        fill_lin(8, 1500);
        for (int r = 0; r < 8; r++) drive(r, 1'b1);
        idle(12);
        check_blocks("rst_blk", 1);

`ifdef TRANSPOSE_PINGPONG_EN
        // Three back-to-back blocks stream without stalls.
        clear_cap();
        fill_lin(24, 0);
        for (int r = 0; r < 24; r++) drive(r, 1'b1);
        idle(14);
        check_blocks("pp", 3);
        check_val("pp_ready_low", rdy_low, 0);
        check_val("pp_drops", drop_cnt, 0);
        check_val("pp_o_drop", int'(o_drop), 0);
`else
        // Sixteen consecutive rows: the second eight are dropped while the bank drains.
        clear_cap();
        fill_lin(16, 0);
        for (int r = 0; r < 16; r++) drive(r, 1'b1);
        idle(12);
        check_blocks("blk16", 1);
        check_val("blk16_accepted", acc_edge.size(), 8);
        check_val("blk16_ready_low", rdy_low, 8);
        check_val("blk16_drops", drop_cnt, 8);
        check_val("blk16_o_drop", int'(o_drop), 1);
        clear_cap();
        fill_lin(8, 600);
        for (int r = 0; r < 8; r++) drive(r, 1'b1);
        idle(12);
        check_blocks("after_drop", 1);
        check_val("drop_sticky", int'(o_drop), 1);
        i_rst = 1'b0;
        step();
        i_rst = 1'b1;
        check_val("drop_cleared", int'(o_drop), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
